// File: rtl/mux_4.sv
// Reference 4:1 WIDTH-bit selector: combinational output y, registered copy y_q,
// and a one-cycle y_chg pulse whenever y_q takes a value different from before.
module mux_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_chg
);

    // Same-cycle selection; all four codes decoded explicitly.
    always_comb begin
        y = d0;
        case (sel)
            2'b00: y = d0;
            2'b01: y = d1;
            2'b10: y = d2;
            2'b11: y = d3;
        endcase
    end

    // Registered copy and change flag, compared against the word currently held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q   <= '0;
            y_chg <= 1'b0;
        end else begin
            y_q   <= y;
            y_chg <= (y != y_q);
        end
    end

endmodule

// File: tb/tb_mux_4.sv
// Bench for mux_4: a WIDTH=4 and a WIDTH=8 instance share select and data
// (the narrow one sees the low nibble), checked against a table-lookup model.
module tb_mux_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel;
    logic [7:0] dv [4];

    logic [3:0] y4, y_q4;
    logic [7:0] y8, y_q8;
    logic       y_chg4, y_chg8;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_4 #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n),
        .d0(dv[0][3:0]), .d1(dv[1][3:0]), .d2(dv[2][3:0]), .d3(dv[3][3:0]),
        .sel(sel), .y(y4), .y_q(y_q4), .y_chg(y_chg4)
    );

    mux_4 #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n),
        .d0(dv[0]), .d1(dv[1]), .d2(dv[2]), .d3(dv[3]),
        .sel(sel), .y(y8), .y_q(y_q8), .y_chg(y_chg8)
    );

    // Reference: selected word is a plain table lookup; registered side keeps
    // the list of words captured since reset (reset counts as capturing zero).
    logic [7:0] hist [$];

    function automatic logic [7:0] pick();
        return dv[sel];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            hist.push_back(8'h00);
        end else begin
            hist.push_back(pick());
            if (hist.size() > 4) void'(hist.pop_front());
        end
    end

    function automatic logic [7:0] exp_q();
        return hist[hist.size()-1];
    endfunction

    function automatic logic exp_chg();
        if (hist.size() < 2) return 1'b0;
        return hist[hist.size()-1] != hist[hist.size()-2];
    endfunction

    function automatic logic exp_chg4();
        if (hist.size() < 2) return 1'b0;
        return hist[hist.size()-1][3:0] != hist[hist.size()-2][3:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_y(input string tag);
        check({tag, "_y8"}, 32'(y8), 32'(pick()));
        check({tag, "_y4"}, 32'(y4), 32'(pick() & 8'h0f));
    endtask

    task automatic check_reg(input string tag);
        check({tag, "_q8"},   32'(y_q8),   32'(exp_q()));
        check({tag, "_chg8"}, 32'(y_chg8), 32'(exp_chg()));
        check({tag, "_q4"},   32'(y_q4),   32'(exp_q() & 8'h0f));
        check({tag, "_chg4"}, 32'(y_chg4), 32'(exp_chg4()));
    endtask

    // Move to the falling edge, check registered outputs, then let the caller drive.
    task automatic to_neg(input string tag);
        @(negedge clk);
        check_reg(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 2'b00;
        dv[0] = 8'h0A; dv[1] = 8'h0B; dv[2] = 8'h0C; dv[3] = 8'h0D;

        repeat (2) @(negedge clk);
        check("rst_q4", 32'(y_q4), 32'h0);
        check("rst_chg4", 32'(y_chg4), 32'h0);
        check_y("rst");
        rst_n = 1'b1;

        // Static select sweep, one step per 10 ns.
        for (int s = 0; s < 4; s++) begin
            to_neg("sweep");
            sel = 2'(s);
            #1 check_y("sweep");
            check("sweep_y4_const", 32'(y4), 32'(4'hA + s));
        end

        // Registered path: 00 -> 01 just before an edge.
        sel = 2'b00;
        repeat (2) to_neg("regpath_pre");
        sel = 2'b01;
        to_neg("regpath");
        check("regpath_q4_B", 32'(y_q4), 32'hB);
        check("regpath_chg4_1", 32'(y_chg4), 32'h1);
        to_neg("regpath_after");
        check("regpath_chg4_0", 32'(y_chg4), 32'h0);

        // No-change: hold sel=10 for three cycles.
        sel = 2'b10;
        to_neg("hold0");
        for (int i = 0; i < 3; i++) begin
            to_neg("hold");
            check("hold_q4_C", 32'(y_q4), 32'hC);
            check("hold_chg4_0", 32'(y_chg4), 32'h0);
        end

        // Unselected inputs do not disturb y.
        sel = 2'b01;
        to_neg("iso0");
        dv[0] = 8'h00; dv[2] = 8'h00; dv[3] = 8'h00;
        #1 check("iso_y4_B", 32'(y4), 32'hB);
        check_y("iso");
        dv[1] = 8'h05;
        #1 check("iso_y4_5", 32'(y4), 32'h5);
        to_neg("iso_edge");
        check("iso_q4_5", 32'(y_q4), 32'h5);
        check("iso_chg4_1", 32'(y_chg4), 32'h1);

        // Async reset mid-run with y_q = D.
        dv[0] = 8'h0A; dv[1] = 8'h0B; dv[2] = 8'h0C; dv[3] = 8'h0D;
        sel = 2'b11;
        repeat (2) to_neg("ar_pre");
        check("ar_pre_q4_D", 32'(y_q4), 32'hD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("ar_q4_0", 32'(y_q4), 32'h0);
        check("ar_chg4_0", 32'(y_chg4), 32'h0);
        check("ar_q8_0", 32'(y_q8), 32'h0);
        check("ar_y4_D", 32'(y4), 32'hD);
        to_neg("ar_low");
        rst_n = 1'b1;
        to_neg("ar_rel");
        check("ar_rel_q4_D", 32'(y_q4), 32'hD);
        check("ar_rel_chg4_1", 32'(y_chg4), 32'h1);

        // WIDTH=8 sweep.
        dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
        for (int s = 0; s < 4; s++) begin
            to_neg("w8");
            sel = 2'(s);
            #1 check_y("w8");
            check("w8_y8_const", 32'(y8), 32'(8'h11 * (s + 1)));
        end

        // Randomized traffic, with frequent holds and occasional async resets.
        for (int i = 0; i < 300; i++) begin
            to_neg("rnd");
            if ($urandom_range(0, 2) != 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                dv[$urandom_range(0, 3)] = 8'($urandom);
            if ($urandom_range(0, 3) == 0) dv[sel] = 8'($urandom_range(0, 3));
            #1 check_y("rnd");
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0;
                #1 check_reg("rnd_rst");
                rst_n = 1'b1;
            end
        end

        to_neg("final");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
